// File: rtl/dtfag_mux_sched.sv
// Twiddle-path sequencer for the radix-16 FFT: walks stages x groups, addresses the DTFAG
// generator and produces the lane-mux select aligned to the generator's output latency.
module dtfag_mux_sched #(
  parameter int NSTAGE = 4,
  parameter int GRP_W  = 12,
  parameter int STG_W  = 2,
  parameter int LAT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic [GRP_W-1:0] grp_idx,
  output logic [STG_W-1:0] stg_idx,
  output logic             issue_vld,
  output logic [1:0]       Mul_sel,
  output logic             mux_vld,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] drain_cnt;
  logic             last_grp;
  logic             last_stg;
  logic             sel_i;
  logic             drain_end;
  logic             vld_p [LAT];
  logic             sel_p [LAT];

  assign last_grp  = (grp_idx == {GRP_W{1'b1}});
  assign last_stg  = (stg_idx == STG_W'(NSTAGE - 1));
  assign drain_end = (drain_cnt == CNT_W'(LAT - 1));

  // The final stage needs no twiddle, so its multiplier inputs are gated to zero.
  assign sel_i = ~last_stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (last_grp && last_stg) state_d = S_DRAIN;
        S_DRAIN: if (drain_end) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A pending DONE is held off while the downstream is stalled.
  always_comb begin
    issue_vld = (state_q == S_RUN);
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE) && !hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_idx   <= '0;
      stg_idx   <= '0;
      drain_cnt <= '0;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            grp_idx <= '0;
            stg_idx <= '0;
          end
          drain_cnt <= '0;
        end
        S_RUN: begin
          drain_cnt <= '0;
          if (last_grp) begin
            grp_idx <= '0;
            stg_idx <= last_stg ? '0 : stg_idx + STG_W'(1);
          end else begin
            grp_idx <= grp_idx + GRP_W'(1);
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + CNT_W'(1);
        default: drain_cnt <= '0;
      endcase
    end
  end

  // Delay line stage 0: captures the issue; the tail lines up with the generator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_p[i] <= 1'b0;
        sel_p[i] <= 1'b0;
      end
    end else if (!hold) begin
      vld_p[0] <= issue_vld;
      sel_p[0] <= issue_vld & sel_i;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        sel_p[i] <= sel_p[i-1];
      end
    end
  end

  // Delay line tail: select is forced low whenever the lane output is not valid.
  always_comb begin
    mux_vld = vld_p[LAT-1];
    Mul_sel = vld_p[LAT-1] ? {1'b0, sel_p[LAT-1]} : 2'b00;
  end

endmodule

// File: tb/tb_dtfag_mux_sched.sv
// Directed bench for dtfag_mux_sched at default parameters (4 stages x 4096 groups, LAT=3).
module tb_dtfag_mux_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hold;
  logic [11:0] grp_idx;
  logic [1:0]  stg_idx;
  logic        issue_vld;
  logic [1:0]  Mul_sel;
  logic        mux_vld;
  logic        busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  dtfag_mux_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .grp_idx   (grp_idx),
    .stg_idx   (stg_idx),
    .issue_vld (issue_vld),
    .Mul_sel   (Mul_sel),
    .mux_vld   (mux_vld),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 70000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse start; afterwards cyc = 1 is the first RUN cycle.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  // Runs until the transform is back in IDLE, recording the first done cycle and done count.
  task automatic wait_end(input int limit, output int first_done, output int ndone);
    first_done = -1;
    ndone = 0;
    while (cyc < limit) begin
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = cyc;
      end else if (ndone > 0 && busy === 1'b0) begin
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; hold = 1'b0;
    tick();
    tick();
    vec_cnt += 7;
    if (grp_idx !== 12'd0)  begin err_cnt++; $display("FAIL reset grp_idx got %0d want 0", grp_idx); end
    if (stg_idx !== 2'd0)   begin err_cnt++; $display("FAIL reset stg_idx got %0d want 0", stg_idx); end
    if (issue_vld !== 1'b0) begin err_cnt++; $display("FAIL reset issue_vld got %b want 0", issue_vld); end
    if (Mul_sel !== 2'd0)   begin err_cnt++; $display("FAIL reset Mul_sel got %0d want 0", Mul_sel); end
    if (mux_vld !== 1'b0)   begin err_cnt++; $display("FAIL reset mux_vld got %b want 0", mux_vld); end
    if (busy !== 1'b0)      begin err_cnt++; $display("FAIL reset busy got %b want 0", busy); end
    if (done !== 1'b0)      begin err_cnt++; $display("FAIL reset done got %b want 0", done); end
    rst = 1'b0; start = 1'b0;
    tick();
    vec_cnt += 2;
    if (busy !== 1'b0)      begin err_cnt++; $display("FAIL post_reset busy got %b want 0", busy); end
    if (issue_vld !== 1'b0) begin err_cnt++; $display("FAIL post_reset issue_vld got %b want 0", issue_vld); end
  endtask

  // Cycle-exact check of a complete undisturbed transform.
  task automatic test_full_run();
    logic        e_iv, e_mv, e_done, e_busy;
    logic [1:0]  e_ms;
    logic [11:0] e_grp;
    logic [1:0]  e_stg;
    start_run();
    while (cyc <= 16389) begin
      e_iv   = (cyc <= 16384);
      e_grp  = 12'((cyc - 1) % 4096);
      e_stg  = 2'((cyc - 1) / 4096);
      e_mv   = (cyc >= 4) && (cyc <= 16387);
      e_ms   = (e_mv && cyc <= 12291) ? 2'd1 : 2'd0;
      e_done = (cyc == 16388);
      e_busy = (cyc <= 16387);
      vec_cnt += 5;
      if (issue_vld !== e_iv) begin err_cnt++; $display("FAIL full issue_vld cyc %0d got %b want %b", cyc, issue_vld, e_iv); end
      if (mux_vld !== e_mv)   begin err_cnt++; $display("FAIL full mux_vld cyc %0d got %b want %b", cyc, mux_vld, e_mv); end
      if (Mul_sel !== e_ms)   begin err_cnt++; $display("FAIL full Mul_sel cyc %0d got %0d want %0d", cyc, Mul_sel, e_ms); end
      if (done !== e_done)    begin err_cnt++; $display("FAIL full done cyc %0d got %b want %b", cyc, done, e_done); end
      if (busy !== e_busy)    begin err_cnt++; $display("FAIL full busy cyc %0d got %b want %b", cyc, busy, e_busy); end
      if (e_iv) begin
        vec_cnt += 2;
        if (grp_idx !== e_grp) begin err_cnt++; $display("FAIL full grp_idx cyc %0d got %0d want %0d", cyc, grp_idx, e_grp); end
        if (stg_idx !== e_stg) begin err_cnt++; $display("FAIL full stg_idx cyc %0d got %0d want %0d", cyc, stg_idx, e_stg); end
      end
      tick();
    end
  endtask

  // Starts a run and pulses start again at grp 50; the run must carry on unchanged.
  task automatic test_start_mid_run();
    start_run();
    go_to(51);
    vec_cnt++;
    if (grp_idx !== 12'd50) begin err_cnt++; $display("FAIL mid_start pre grp_idx got %0d want 50", grp_idx); end
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_cnt += 3;
    if (grp_idx !== 12'd51) begin err_cnt++; $display("FAIL mid_start grp_idx got %0d want 51", grp_idx); end
    if (busy !== 1'b1)      begin err_cnt++; $display("FAIL mid_start busy got %b want 1", busy); end
    if (stg_idx !== 2'd0)   begin err_cnt++; $display("FAIL mid_start stg_idx got %0d want 0", stg_idx); end
    tick();
    vec_cnt++;
    if (grp_idx !== 12'd52) begin err_cnt++; $display("FAIL mid_start next grp_idx got %0d want 52", grp_idx); end
  endtask

  // Continues the same run: 5-cycle stall at grp 100 of stage 2.
  task automatic test_hold();
    go_to(8293);
    vec_cnt += 2;
    if (grp_idx !== 12'd100) begin err_cnt++; $display("FAIL hold pre grp_idx got %0d want 100", grp_idx); end
    if (stg_idx !== 2'd2)    begin err_cnt++; $display("FAIL hold pre stg_idx got %0d want 2", stg_idx); end
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vec_cnt += 6;
      if (grp_idx !== 12'd100) begin err_cnt++; $display("FAIL hold grp_idx k %0d got %0d want 100", k, grp_idx); end
      if (stg_idx !== 2'd2)    begin err_cnt++; $display("FAIL hold stg_idx k %0d got %0d want 2", k, stg_idx); end
      if (issue_vld !== 1'b1)  begin err_cnt++; $display("FAIL hold issue_vld k %0d got %b want 1", k, issue_vld); end
      if (mux_vld !== 1'b1)    begin err_cnt++; $display("FAIL hold mux_vld k %0d got %b want 1", k, mux_vld); end
      if (Mul_sel !== 2'd1)    begin err_cnt++; $display("FAIL hold Mul_sel k %0d got %0d want 1", k, Mul_sel); end
      if (done !== 1'b0)       begin err_cnt++; $display("FAIL hold done k %0d got %b want 0", k, done); end
    end
    hold = 1'b0;
    tick();
    vec_cnt++;
    if (grp_idx !== 12'd101) begin err_cnt++; $display("FAIL hold release grp_idx got %0d want 101", grp_idx); end
  endtask

  // Continues the same run (5 cycles late): stage 2 -> 3 boundary, then a single done.
  task automatic test_stage_boundary();
    int first_done, ndone;
    go_to(12293);
    vec_cnt += 2;
    if (grp_idx !== 12'd4095) begin err_cnt++; $display("FAIL bound last grp_idx got %0d want 4095", grp_idx); end
    if (stg_idx !== 2'd2)     begin err_cnt++; $display("FAIL bound last stg_idx got %0d want 2", stg_idx); end
    tick();
    vec_cnt += 3;
    if (grp_idx !== 12'd0)  begin err_cnt++; $display("FAIL bound next grp_idx got %0d want 0", grp_idx); end
    if (stg_idx !== 2'd3)   begin err_cnt++; $display("FAIL bound next stg_idx got %0d want 3", stg_idx); end
    if (issue_vld !== 1'b1) begin err_cnt++; $display("FAIL bound next issue_vld got %b want 1", issue_vld); end
    go_to(12296);
    vec_cnt += 2;
    if (mux_vld !== 1'b1) begin err_cnt++; $display("FAIL bound stg2 mux_vld got %b want 1", mux_vld); end
    if (Mul_sel !== 2'd1) begin err_cnt++; $display("FAIL bound stg2 Mul_sel got %0d want 1", Mul_sel); end
    tick();
    vec_cnt += 2;
    if (mux_vld !== 1'b1) begin err_cnt++; $display("FAIL bound stg3 mux_vld got %b want 1", mux_vld); end
    if (Mul_sel !== 2'd0) begin err_cnt++; $display("FAIL bound stg3 Mul_sel got %0d want 0", Mul_sel); end
    wait_end(16500, first_done, ndone);
    vec_cnt += 3;
    if (first_done !== 16393) begin err_cnt++; $display("FAIL bound done_cycle got %0d want 16393", first_done); end
    if (ndone !== 1)          begin err_cnt++; $display("FAIL bound done_count got %0d want 1", ndone); end
    if (busy !== 1'b0)        begin err_cnt++; $display("FAIL bound end busy got %b want 0", busy); end
  endtask

  task automatic test_rst_mid_run();
    start_run();
    go_to(6097);
    vec_cnt += 2;
    if (grp_idx !== 12'd2000) begin err_cnt++; $display("FAIL rst_mid pre grp_idx got %0d want 2000", grp_idx); end
    if (stg_idx !== 2'd1)     begin err_cnt++; $display("FAIL rst_mid pre stg_idx got %0d want 1", stg_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt += 7;
    if (grp_idx !== 12'd0)  begin err_cnt++; $display("FAIL rst_mid grp_idx got %0d want 0", grp_idx); end
    if (stg_idx !== 2'd0)   begin err_cnt++; $display("FAIL rst_mid stg_idx got %0d want 0", stg_idx); end
    if (issue_vld !== 1'b0) begin err_cnt++; $display("FAIL rst_mid issue_vld got %b want 0", issue_vld); end
    if (Mul_sel !== 2'd0)   begin err_cnt++; $display("FAIL rst_mid Mul_sel got %0d want 0", Mul_sel); end
    if (mux_vld !== 1'b0)   begin err_cnt++; $display("FAIL rst_mid mux_vld got %b want 0", mux_vld); end
    if (busy !== 1'b0)      begin err_cnt++; $display("FAIL rst_mid busy got %b want 0", busy); end
    if (done !== 1'b0)      begin err_cnt++; $display("FAIL rst_mid done got %b want 0", done); end
    for (int k = 0; k < 6; k++) begin
      tick();
      vec_cnt += 3;
      if (done !== 1'b0)      begin err_cnt++; $display("FAIL rst_mid after done k %0d got %b want 0", k, done); end
      if (mux_vld !== 1'b0)   begin err_cnt++; $display("FAIL rst_mid after mux_vld k %0d got %b want 0", k, mux_vld); end
      if (issue_vld !== 1'b0) begin err_cnt++; $display("FAIL rst_mid after issue_vld k %0d got %b want 0", k, issue_vld); end
    end
    test_full_run();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    test_reset();
    test_full_run();
    test_start_mid_run();
    test_hold();
    test_stage_boundary();
    test_rst_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
